// File: rtl/ti_stop_controller.sv
// Task-level stop sequencer: fans one host stop request out to NUM_IF read/write wrapper pairs,
// aggregates their acks, and tracks timeout and stop latency.
module ti_stop_controller #(
  parameter int unsigned                 NUM_IF         = 4,
  parameter int unsigned                 TIMEOUT_BITS   = 16,
  parameter logic [TIMEOUT_BITS-1:0]     TIMEOUT_CYCLES = 16'd4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    task_stop_req_i,
  output logic                    task_stop_ack_o,
  input  logic [NUM_IF-1:0]       if_mask_i,
  output logic [2*NUM_IF-1:0]     stop_req_o,
  input  logic [2*NUM_IF-1:0]     stop_ack_i,
  output logic                    timeout_o,
  output logic [TIMEOUT_BITS-1:0] stop_latency_o,
  output logic                    busy_o
);

  typedef enum logic [1:0] {StIdle, StWait, StStopped, StRelease} state_e;

  localparam logic [TIMEOUT_BITS-1:0] CntOne  = TIMEOUT_BITS'(1);
  localparam logic [TIMEOUT_BITS-1:0] CntLast = TIMEOUT_CYCLES - CntOne;

  state_e                  state_q;
  logic [NUM_IF-1:0]       mask_q;
  logic [2*NUM_IF-1:0]     stop_req_q;
  logic                    ack_q;
  logic                    timeout_q;
  logic [TIMEOUT_BITS-1:0] cnt_q;
  logic [TIMEOUT_BITS-1:0] latency_q;

  logic [2*NUM_IF-1:0]     m2_mask;
  logic [2*NUM_IF-1:0]     m2_in;
  logic                    all_acked;
  logic                    all_clear;

  // Each wrapper owns a write/read pair, so every mask bit covers two request/ack bits.
  always_comb begin
    m2_mask = '0;
    m2_in   = '0;
    for (int i = 0; i < NUM_IF; i++) begin
      m2_mask[2*i +: 2] = {2{mask_q[i]}};
      m2_in[2*i +: 2]   = {2{if_mask_i[i]}};
    end
    all_acked = &(stop_ack_i | ~m2_mask);
    all_clear = ~|stop_ack_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mask_q     <= '0;
      stop_req_q <= '0;
      ack_q      <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
      latency_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (task_stop_req_i) begin
            mask_q     <= if_mask_i;
            stop_req_q <= m2_in;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
            state_q    <= StWait;
          end
        end
        StWait: begin
          // Abort beats success, success beats timeout.
          if (!task_stop_req_i) begin
            stop_req_q <= '0;
            state_q    <= StRelease;
          end else if (all_acked) begin
            latency_q <= cnt_q + CntOne;
            ack_q     <= 1'b1;
            state_q   <= StStopped;
          end else if (cnt_q == CntLast) begin
            timeout_q  <= 1'b1;
            stop_req_q <= '0;
            state_q    <= StRelease;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StStopped: begin
          if (!task_stop_req_i) begin
            stop_req_q <= '0;
            state_q    <= StRelease;
          end
        end
        StRelease: begin
          // Requiring the request low forces the host to re-raise it after a timeout.
          if (all_clear && !task_stop_req_i) begin
            ack_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign task_stop_ack_o = ack_q;
  assign stop_req_o      = stop_req_q;
  assign timeout_o       = timeout_q;
  assign stop_latency_o  = latency_q;
  assign busy_o          = (state_q != StIdle);

endmodule

// File: tb/tb_ti_stop_controller.sv
// Directed bench for ti_stop_controller with two wrappers and a short timeout.
module tb_ti_stop_controller;

  localparam int unsigned NIF = 2;
  localparam int unsigned TB  = 16;

  logic          clk;
  logic          rst_n;
  logic          task_stop_req;
  logic          task_stop_ack;
  logic [NIF-1:0]   if_mask;
  logic [2*NIF-1:0] stop_req;
  logic [2*NIF-1:0] stop_ack;
  logic          timeout;
  logic [TB-1:0] stop_latency;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  ti_stop_controller #(
    .NUM_IF        (NIF),
    .TIMEOUT_BITS  (TB),
    .TIMEOUT_CYCLES(16'd8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .task_stop_req_i(task_stop_req),
    .task_stop_ack_o(task_stop_ack),
    .if_mask_i      (if_mask),
    .stop_req_o     (stop_req),
    .stop_ack_i     (stop_ack),
    .timeout_o      (timeout),
    .stop_latency_o (stop_latency),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; task_stop_req = 1'b0; if_mask = '0; stop_ack = '0;
    #12;
    n_checks++;
    if ({stop_req, task_stop_ack, timeout, stop_latency, busy} !== '0)
      $display("FAIL reset_outputs: got req=%b ack=%b to=%b lat=%0d busy=%b want all 0",
               stop_req, task_stop_ack, timeout, stop_latency, busy);
    else n_pass++;
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_nominal();
    task_stop_req = 1'b1; if_mask = 2'b11;        // cycle 0
    tick(1);                                      // edge 1
    n_checks++;
    if (stop_req !== 4'b1111 || busy !== 1'b1)
      $display("FAIL nom_req_rise: got req=%b busy=%b want 1111 1", stop_req, busy);
    else n_pass++;
    tick(4);                                      // edge 5
    stop_ack = 4'b1111;
    n_checks++;
    if (task_stop_ack !== 1'b0)
      $display("FAIL nom_ack_early: got %b want 0", task_stop_ack);
    else n_pass++;
    tick(1);                                      // edge 6
    n_checks++;
    if (task_stop_ack !== 1'b1 || stop_latency !== 16'd5)
      $display("FAIL nom_ack: got ack=%b lat=%0d want 1 5", task_stop_ack, stop_latency);
    else n_pass++;
    tick(4);                                      // edge 10
    task_stop_req = 1'b0;
    tick(1);                                      // edge 11
    n_checks++;
    if (stop_req !== 4'b0000 || task_stop_ack !== 1'b1)
      $display("FAIL nom_release: got req=%b ack=%b want 0000 1", stop_req, task_stop_ack);
    else n_pass++;
    tick(1);                                      // edge 12
    stop_ack = 4'b0000;
    n_checks++;
    if (busy !== 1'b1 || task_stop_ack !== 1'b1)
      $display("FAIL nom_hold_release: got busy=%b ack=%b want 1 1", busy, task_stop_ack);
    else n_pass++;
    tick(1);                                      // edge 13
    n_checks++;
    if (task_stop_ack !== 1'b0 || busy !== 1'b0)
      $display("FAIL nom_idle: got ack=%b busy=%b want 0 0", task_stop_ack, busy);
    else n_pass++;
  endtask

  task automatic test_partial_mask();
    task_stop_req = 1'b1; if_mask = 2'b01;
    tick(1);
    n_checks++;
    if (stop_req !== 4'b0011)
      $display("FAIL mask_req: got %b want 0011", stop_req);
    else n_pass++;
    stop_ack = 4'b0100;
    tick(1);
    n_checks++;
    if (task_stop_ack !== 1'b0)
      $display("FAIL mask_masked_ack: got %b want 0", task_stop_ack);
    else n_pass++;
    stop_ack = 4'b0011;
    tick(1);
    n_checks++;
    if (task_stop_ack !== 1'b1 || stop_latency !== 16'd2)
      $display("FAIL mask_ack: got ack=%b lat=%0d want 1 2", task_stop_ack, stop_latency);
    else n_pass++;
    stop_ack = 4'b1111; if_mask = 2'b10;
    tick(1);
    stop_ack = 4'b0000;
    tick(1);
    n_checks++;
    if (stop_req !== 4'b0011 || task_stop_ack !== 1'b1 || busy !== 1'b1)
      $display("FAIL mask_stopped_hold: got req=%b ack=%b busy=%b want 0011 1 1",
               stop_req, task_stop_ack, busy);
    else n_pass++;
    task_stop_req = 1'b0;
    tick(2);
    n_checks++;
    if (busy !== 1'b0 || task_stop_ack !== 1'b0)
      $display("FAIL mask_idle: got busy=%b ack=%b want 0 0", busy, task_stop_ack);
    else n_pass++;
  endtask

  task automatic test_timeout();
    task_stop_req = 1'b1; if_mask = 2'b11;
    tick(1);                                      // WAIT, counter 0
    stop_ack = 4'b0001;
    tick(7);                                      // counter 7
    n_checks++;
    if (timeout !== 1'b0 || stop_req !== 4'b1111)
      $display("FAIL to_before: got to=%b req=%b want 0 1111", timeout, stop_req);
    else n_pass++;
    tick(1);
    n_checks++;
    if (timeout !== 1'b1 || stop_req !== 4'b0000 || task_stop_ack !== 1'b0)
      $display("FAIL to_expire: got to=%b req=%b ack=%b want 1 0000 0",
               timeout, stop_req, task_stop_ack);
    else n_pass++;
    stop_ack = 4'b0000;
    tick(3);
    n_checks++;
    if (busy !== 1'b1 || stop_req !== 4'b0000 || task_stop_ack !== 1'b0)
      $display("FAIL to_held: got busy=%b req=%b ack=%b want 1 0000 0",
               busy, stop_req, task_stop_ack);
    else n_pass++;
    task_stop_req = 1'b0;
    tick(1);
    n_checks++;
    if (busy !== 1'b0 || timeout !== 1'b1)
      $display("FAIL to_idle: got busy=%b to=%b want 0 1", busy, timeout);
    else n_pass++;
    task_stop_req = 1'b1;
    tick(1);
    n_checks++;
    if (timeout !== 1'b0 || stop_req !== 4'b1111)
      $display("FAIL to_rearm: got to=%b req=%b want 0 1111", timeout, stop_req);
    else n_pass++;
    stop_ack = 4'b1111;
    tick(1);
    n_checks++;
    if (task_stop_ack !== 1'b1 || stop_latency !== 16'd1)
      $display("FAIL to_rearm_ack: got ack=%b lat=%0d want 1 1", task_stop_ack, stop_latency);
    else n_pass++;
    task_stop_req = 1'b0; stop_ack = 4'b0000;
    tick(2);
  endtask

  task automatic test_abort();
    task_stop_req = 1'b1; if_mask = 2'b11;
    tick(1);
    stop_ack = 4'b0011;
    tick(1);
    task_stop_req = 1'b0;
    tick(1);
    n_checks++;
    if (stop_req !== 4'b0000 || task_stop_ack !== 1'b0 || timeout !== 1'b0 || busy !== 1'b1)
      $display("FAIL abort_release: got req=%b ack=%b to=%b busy=%b want 0000 0 0 1",
               stop_req, task_stop_ack, timeout, busy);
    else n_pass++;
    tick(1);
    n_checks++;
    if (busy !== 1'b1)
      $display("FAIL abort_wait_clear: got busy=%b want 1", busy);
    else n_pass++;
    stop_ack = 4'b0000;
    tick(1);
    n_checks++;
    if (busy !== 1'b0 || stop_latency !== 16'd1 || task_stop_ack !== 1'b0)
      $display("FAIL abort_idle: got busy=%b lat=%0d ack=%b want 0 1 0",
               busy, stop_latency, task_stop_ack);
    else n_pass++;
  endtask

  task automatic test_ack_at_timeout();
    task_stop_req = 1'b1; if_mask = 2'b11;
    tick(8);                                      // counter 7, last WAIT cycle
    stop_ack = 4'b1111;
    tick(1);
    n_checks++;
    if (task_stop_ack !== 1'b1 || timeout !== 1'b0 || stop_latency !== 16'd8 ||
        stop_req !== 4'b1111)
      $display("FAIL tie_success: got ack=%b to=%b lat=%0d req=%b want 1 0 8 1111",
               task_stop_ack, timeout, stop_latency, stop_req);
    else n_pass++;
    task_stop_req = 1'b0; stop_ack = 4'b0000;
    tick(2);
  endtask

  task automatic test_zero_mask();
    task_stop_req = 1'b1; if_mask = 2'b00;
    tick(1);
    n_checks++;
    if (stop_req !== 4'b0000 || task_stop_ack !== 1'b0 || busy !== 1'b1)
      $display("FAIL zero_wait: got req=%b ack=%b busy=%b want 0000 0 1",
               stop_req, task_stop_ack, busy);
    else n_pass++;
    tick(1);
    n_checks++;
    if (task_stop_ack !== 1'b1 || stop_latency !== 16'd1)
      $display("FAIL zero_ack: got ack=%b lat=%0d want 1 1", task_stop_ack, stop_latency);
    else n_pass++;
    task_stop_req = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_mid_stop();
    task_stop_req = 1'b1; if_mask = 2'b11;
    tick(3);
    stop_ack = 4'b1111;
    tick(1);                                      // STOPPED, latency 3
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({stop_req, task_stop_ack, timeout, stop_latency, busy} !== '0)
      $display("FAIL rst_async: got req=%b ack=%b to=%b lat=%0d busy=%b want all 0",
               stop_req, task_stop_ack, timeout, stop_latency, busy);
    else n_pass++;
    task_stop_req = 1'b0; stop_ack = 4'b0000;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    task_stop_req = 1'b1; if_mask = 2'b10;
    tick(1);
    n_checks++;
    if (stop_req !== 4'b1100)
      $display("FAIL rst_after_req: got %b want 1100", stop_req);
    else n_pass++;
    stop_ack = 4'b1100;
    tick(1);
    n_checks++;
    if (task_stop_ack !== 1'b1 || stop_latency !== 16'd1)
      $display("FAIL rst_after_ack: got ack=%b lat=%0d want 1 1", task_stop_ack, stop_latency);
    else n_pass++;
    task_stop_req = 1'b0; stop_ack = 4'b0000;
    tick(2);
    n_checks++;
    if (busy !== 1'b0 || task_stop_ack !== 1'b0)
      $display("FAIL rst_after_idle: got busy=%b ack=%b want 0 0", busy, task_stop_ack);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_partial_mask();
    test_timeout();
    test_abort();
    test_ack_at_timeout();
    test_zero_mask();
    test_reset_mid_stop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ti_stop_controller.md
Name: ti_stop_controller

Overview:
- Central sequencer for safe task interruption.
- Takes one task-level stop request from the context-switch host and fans it out as per-channel stop requests to NUM_IF AXI task-interruption wrappers. Each wrapper has bit 0 = write, bit 1 = read.
- Aggregates the wrappers' stop acks into a single task-level ack.
- Also provides timeout/abort handling, a per-interface enable mask and a stop-latency measurement.

Parameters:
- NUM_IF, 4: number of attached wrappers; each has a 2-bit stop_req/stop_ack pair.
- TIMEOUT_BITS, 16: width of the cycle counter and of stop_latency.
- TIMEOUT_CYCLES, 16'd4096: cycles allowed in WAIT before timeout; must be >= 1 and < 2^TIMEOUT_BITS.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- task_stop_req  in  1  level request from host; held high to stop, dropped to resume
- task_stop_ack  out  1  high while all enabled wrappers are stopped
- if_mask  in  NUM_IF  bit i = 1 stops wrapper i; sampled on leaving IDLE
- stop_req  out  2*NUM_IF  to wrappers; bits [2i+1:2i] belong to wrapper i
- stop_ack  in  2*NUM_IF  from wrappers, same packing
- timeout  out  1  sticky: last stop attempt timed out
- stop_latency  out  TIMEOUT_BITS  cycles from stop_req assertion to all-acked, for the last successful stop
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous) drives all outputs to 0:
  - state=IDLE, stop_req=0, task_stop_ack=0, timeout=0, stop_latency=0.
  - Mask register=0, counter=0.
- All outputs are registered. No combinational path from any input to any output.
- Expanded mask: m2[2i+1:2i] = {2{mask_reg[i]}}.
- all_acked = &(stop_ack | ~m2).
- all_clear = ~|stop_ack. Masked-off bits are ignored for all_acked; all bits are checked for all_clear.
- IDLE:
  - When task_stop_req=1: latch mask_reg<=if_mask, stop_req<=m2 of if_mask, counter<=0, timeout<=0, go to WAIT.
  - stop_req rises exactly 1 cycle after task_stop_req is sampled high.
- WAIT, priority order:
  1. task_stop_req=0 (abort): stop_req<=0, go to RELEASE. timeout unchanged, task_stop_ack stays 0.
  2. all_acked: stop_latency<=counter+1, task_stop_ack<=1, go to STOPPED.
  3. counter==TIMEOUT_CYCLES-1: timeout<=1, stop_req<=0, go to RELEASE.
  4. Otherwise: counter<=counter+1. The counter never wraps.
- If mask_reg==0, all_acked is true on the first WAIT cycle. Ack rises 2 cycles after request, stop_latency=1.
- STOPPED:
  - Hold stop_req and task_stop_ack=1.
  - A wrapper dropping its ack while stopped does not change state.
  - On task_stop_req=0: stop_req<=0, go to RELEASE. task_stop_ack stays 1.
- RELEASE:
  - stop_req=0.
  - Exit to IDLE only when all_clear and task_stop_req=0. On exit, task_stop_ack<=0.
  - Because the exit requires task_stop_req=0, a held request after timeout cannot re-trigger. The host must drop and re-raise it.
- Simultaneous events:
  - Abort has priority over all_acked, which has priority over timeout.
  - all_acked in the same cycle as timeout expiry counts as success.
- if_mask changes outside IDLE are ignored.
- stop_latency holds its value until the next successful stop.
- timeout is cleared only on the next IDLE->WAIT transition or reset.
- Reset asserted mid-operation returns to the reset values immediately. Wrappers see stop_req fall asynchronously.

Test Plan:
- NUM_IF=2, if_mask=2'b11; raise task_stop_req at cycle 0, acks return at cycle 5 -> stop_req=4'b1111 from cycle 1, task_stop_ack=1 at cycle 6, stop_latency=5; drop request at cycle 10, acks clear at cycle 12 -> stop_req=0 at cycle 11, task_stop_ack=0 at cycle 13, busy=0.
- if_mask=2'b01, only bits [1:0] acked -> stop_req=4'b0011, task_stop_ack=1; bits [3:2] of stop_ack toggling have no effect.
- TIMEOUT_CYCLES=8, one ack never asserted, request held -> timeout=1 and stop_req=0 at cycle 9 after entering WAIT, task_stop_ack never 1, state stays RELEASE until task_stop_req=0, then IDLE; re-request clears timeout.
- Drop task_stop_req while in WAIT with partial acks -> stop_req=0 next cycle, task_stop_ack stays 0, timeout stays 0, IDLE once acks clear.
- all_acked and timeout expiry in the same cycle -> STOPPED, timeout=0, stop_latency=TIMEOUT_CYCLES.
- Assert rst_n low mid-STOPPED -> all outputs 0 without a clock edge; after release, normal stop sequence works.
